// File: rtl/div_sequencer_if.sv
// Handshake and result bundle between the CPU issue logic (master) and the
// sequential divider (slave).
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider: one quotient bit per clock on operand
// magnitudes, with the sign fix-up applied in a final FIX cycle.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           clear,
    div_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state_reg;
    logic             dvd_neg_reg;
    logic             dvs_neg_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] quo_reg;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] q_out_reg;
    logic [WIDTH-1:0] r_out_reg;
    logic             dbz_reg;
    logic             done_reg;

    logic             in_dvd_neg;
    logic             in_dvs_neg;
    logic [WIDTH-1:0] in_dvd_mag;
    logic [WIDTH-1:0] in_dvs_mag;
    logic [WIDTH:0]   rem_shift;
    logic             step_ge;
    logic [WIDTH-1:0] rem_step;

    // Sign flags already fold in signed_op, so unsigned ops never negate.
    assign in_dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign in_dvs_neg = bus.signed_op & bus.divisor[WIDTH-1];
    assign in_dvd_mag = in_dvd_neg ? -bus.dividend : bus.dividend;
    assign in_dvs_mag = in_dvs_neg ? -bus.divisor  : bus.divisor;

    // The true difference is below the divisor, so WIDTH-bit subtraction suffices.
    assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign step_ge   = rem_shift >= {1'b0, dvs_reg};
    assign rem_step  = step_ge ? (rem_shift[WIDTH-1:0] - dvs_reg) : rem_shift[WIDTH-1:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg   <= IDLE;
            dvd_neg_reg <= 1'b0;
            dvs_neg_reg <= 1'b0;
            zero_reg    <= 1'b0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            rem_reg     <= '0;
            count_reg   <= '0;
            q_out_reg   <= '0;
            r_out_reg   <= '0;
            dbz_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        dvd_neg_reg <= in_dvd_neg;
                        dvs_neg_reg <= in_dvs_neg;
                        zero_reg    <= (bus.divisor == '0);
                        dvs_reg     <= in_dvs_mag;
                        rem_reg     <= '0;
                        count_reg   <= '0;
                        // A zero divisor skips ITER, so keep the raw dividend for the remainder.
                        if (bus.divisor == '0) begin
                            quo_reg   <= bus.dividend;
                            state_reg <= FIX;
                        end else begin
                            quo_reg   <= in_dvd_mag;
                            state_reg <= ITER;
                        end
                    end
                end
                ITER: begin
                    quo_reg   <= {quo_reg[WIDTH-2:0], step_ge};
                    rem_reg   <= rem_step;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(WIDTH - 1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    if (zero_reg) begin
                        q_out_reg <= '1;
                        r_out_reg <= quo_reg;
                        dbz_reg   <= 1'b1;
                    end else begin
                        q_out_reg <= (dvd_neg_reg ^ dvs_neg_reg) ? -quo_reg : quo_reg;
                        r_out_reg <= dvd_neg_reg ? -rem_reg : rem_reg;
                        dbz_reg   <= 1'b0;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.quotient    = q_out_reg;
    assign bus.remainder   = r_out_reg;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: results, latency, busy/done shape,
// zero divisor, overflow, ignored restarts and mid-operation clear.
module tb_div_sequencer;
    logic clock;
    logic clear;
    int   checks;
    int   errors;

    div_sequencer_if #(.WIDTH(32)) bus ();

    div_sequencer #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drives one division from a post-edge point and measures edges to done.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_cyc, output logic overlap);
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat       = -1;
        overlap   = 1'b0;
        busy_cyc  = bus.busy ? 1 : 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clock); #1;
            if (bus.done) begin
                lat     = n;
                overlap = bus.busy;
                break;
            end
            if (bus.busy) busy_cyc++;
        end
        $display("div s=%0d %h / %h -> q=%h r=%h dbz=%0d lat=%0d",
                 s, a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat);
    endtask

    task automatic test_reset();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
        checks++; if (bus.quotient !== 32'h0) begin errors++; $display("FAIL reset_q got %h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 32'h0) begin errors++; $display("FAIL reset_r got %h want 0", bus.remainder); end
    endtask

    task automatic test_unsigned();
        int lat, bc; logic ov;
        run_div(1'b0, 32'd100, 32'd7, lat, bc, ov);
        checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL u_q got %h want 0000000e", bus.quotient); end
        checks++; if (bus.remainder !== 32'd2) begin errors++; $display("FAIL u_r got %h want 00000002", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL u_dbz got %b want 0", bus.div_by_zero); end
        checks++; if (lat != 33) begin errors++; $display("FAIL u_latency got %0d edges want 33", lat); end
        checks++; if (bc != 33) begin errors++; $display("FAIL u_busy_cycles got %0d want 33", bc); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL u_busy_with_done got %b want 0", ov); end
        @(posedge clock); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL u_done_width got %b want 0", bus.done); end
    endtask

    task automatic test_signed();
        int lat, bc; logic ov;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc, ov);
        checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s1_q got %h want fffffffd", bus.quotient); end
        checks++; if (bus.remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL s1_r got %h want ffffffff", bus.remainder); end
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bc, ov);
        checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s2_q got %h want fffffffd", bus.quotient); end
        checks++; if (bus.remainder !== 32'd1) begin errors++; $display("FAIL s2_r got %h want 00000001", bus.remainder); end
        checks++; if (lat != 33) begin errors++; $display("FAIL s2_latency got %0d want 33", lat); end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic ov;
        run_div(1'b0, 32'd5, 32'd0, lat, bc, ov);
        checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL z_q got %h want ffffffff", bus.quotient); end
        checks++; if (bus.remainder !== 32'd5) begin errors++; $display("FAIL z_r got %h want 00000005", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL z_dbz got %b want 1", bus.div_by_zero); end
        checks++; if (lat != 1) begin errors++; $display("FAIL z_latency got %0d want 1", lat); end
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, lat, bc, ov);
        checks++; if (bus.remainder !== 32'hFFFF_FFFB) begin errors++; $display("FAIL zs_r got %h want fffffffb", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL zs_dbz got %b want 1", bus.div_by_zero); end
        run_div(1'b0, 32'd9, 32'd3, lat, bc, ov);
        checks++; if (bus.quotient !== 32'd3) begin errors++; $display("FAIL z9_q got %h want 00000003", bus.quotient); end
        checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL z9_r got %h want 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL z9_dbz got %b want 0", bus.div_by_zero); end
    endtask

    task automatic test_overflow();
        int lat, bc; logic ov;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, ov);
        checks++; if (bus.quotient !== 32'h8000_0000) begin errors++; $display("FAIL ovs_q got %h want 80000000", bus.quotient); end
        checks++; if (bus.remainder !== 32'h0) begin errors++; $display("FAIL ovs_r got %h want 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL ovs_dbz got %b want 0", bus.div_by_zero); end
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, ov);
        checks++; if (bus.quotient !== 32'h0) begin errors++; $display("FAIL ovu_q got %h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 32'h8000_0000) begin errors++; $display("FAIL ovu_r got %h want 80000000", bus.remainder); end
    endtask

    task automatic test_back_to_back();
        int lat;
        lat = -1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd7;
        bus.start     = 1'b1;
        @(posedge clock); #1;
        bus.start    = 1'b0;
        bus.dividend = 32'd12345;
        repeat (5) begin @(posedge clock); #1; end
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int n = 7; n <= 100; n++) begin
            @(posedge clock); #1;
            if (bus.done) begin lat = n; break; end
        end
        $display("div s=0 1000 / 7 (restart ignored) -> q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_first_latency got %0d want 33", lat); end
        checks++; if (bus.quotient !== 32'd142) begin errors++; $display("FAIL b2b_first_q got %h want 0000008e", bus.quotient); end
        checks++; if (bus.remainder !== 32'd6) begin errors++; $display("FAIL b2b_first_r got %h want 00000006", bus.remainder); end
        // Start raised inside the done cycle.
        bus.dividend = 32'd77;
        bus.divisor  = 32'd5;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got %b want 1", bus.busy); end
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clock); #1;
            if (bus.done) begin lat = n; break; end
        end
        $display("div s=0 77 / 5 (done-cycle start) -> q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
        checks++; if (bus.quotient !== 32'd15) begin errors++; $display("FAIL b2b_second_q got %h want 0000000f", bus.quotient); end
        checks++; if (bus.remainder !== 32'd2) begin errors++; $display("FAIL b2b_second_r got %h want 00000002", bus.remainder); end
    endtask

    task automatic test_clear();
        int lat, bc; logic ov; logic saw_done;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd10;
        bus.start     = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        clear = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", bus.busy); end
        checks++; if (bus.quotient !== 32'h0) begin errors++; $display("FAIL clr_q got %h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 32'h0) begin errors++; $display("FAIL clr_r got %h want 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL clr_dbz got %b want 0", bus.div_by_zero); end
        #1;
        clear = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.done) saw_done = 1'b1;
        end
        $display("div s=0 1000 / 10 aborted by clear, done seen=%0d", saw_done);
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL clr_no_done got %b want 0", saw_done); end
        run_div(1'b0, 32'd1000, 32'd10, lat, bc, ov);
        checks++; if (bus.quotient !== 32'd100) begin errors++; $display("FAIL clr_rerun_q got %h want 00000064", bus.quotient); end
        checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL clr_rerun_r got %h want 0", bus.remainder); end
        checks++; if (lat != 33) begin errors++; $display("FAIL clr_rerun_latency got %0d want 33", lat); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'h0;
        bus.divisor   = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        clear = 1'b0;
        @(posedge clock); #1;
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequential 32-bit integer divider controller for the CPU's DIV instruction. It accepts one operand pair per start pulse and runs one restoring-division step per clock. It applies signed or unsigned semantics and returns quotient and remainder for the HI/LO write-back path with a single-cycle done pulse. It replaces single-evaluation combinational division so that the datapath is clocked, stallable and verifiable.

## Interface
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- start  in  1  request a division; sampled only in IDLE
- signed_op  in  1  1 = two's-complement divide, 0 = unsigned; latched with operands
- dividend  in  WIDTH  numerator; latched on the accepting edge
- divisor  in  WIDTH  denominator; latched on the accepting edge
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse: results valid and updated
- div_by_zero  out  1  set with the done pulse when the latched divisor was 0; held until the next completion
- quotient  out  WIDTH  result to LO; held until the next completion
- remainder  out  WIDTH  result to HI; held until the next completion

Clock is `clock`. Reset is `clear`, asynchronous and active-high.

## Operation
- States: IDLE, ITER, FIX.
- IDLE: if start=1 at an edge, latch signed_op, the sign flags, magnitudes |dividend| and |divisor| (absolute value only when signed_op=1), and a zero-divisor flag. Clear the partial remainder and step counter.
  - Divisor ≠ 0: go to ITER.
  - Divisor = 0: go straight to FIX.
- ITER, one step per edge:
  - partial remainder (WIDTH+1 bits) ← {rem, next dividend MSB}
  - trial = rem − |divisor|
  - if trial ≥ 0: rem ← trial and shift in quotient bit 1; else shift in 0
  - counter increments; after the WIDTH-th step, go to FIX.
- FIX, one edge:
  - Normal result: quotient is negated if signed_op and the operand signs differ. Remainder is negated if signed_op and the dividend is negative, so the remainder's sign always follows the dividend.
  - Zero divisor: quotient = all ones, remainder = original dividend, div_by_zero = 1.
  - Otherwise div_by_zero = 0.
  - In all cases: update outputs, assert done, return to IDLE.
- Signed overflow (−2^(WIDTH−1) / −1) gives quotient 0x80000000, remainder 0, div_by_zero 0. No special flag.
- start while busy is ignored; no queueing. Operand changes after acceptance have no effect.
- A start in the done cycle (state is IDLE) is accepted.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; state = IDLE.
- clear asserted mid-operation:
  - Immediately returns to IDLE and zeroes all outputs.
  - The aborted operation produces no done pulse.
- Latency, counted with the start-accepting edge as E0:
  - Normal: ITER runs on E1..E32 and FIX on E33. done is high for exactly the cycle after E33, i.e. 34 cycles after the start cycle.
  - Zero divisor: FIX on E1, so done is high in the cycle after E1.
- busy:
  - Rises after E0.
  - Falls after the FIX edge, in the same cycle done rises.
  - busy and done are never high together.
- Throughput: one division per WIDTH+2 cycles with back-to-back starts.
- quotient, remainder and div_by_zero change only on the FIX edge or on clear.

## Test plan
- Unsigned 100 / 7 → quotient=14, remainder=2, div_by_zero=0. done is a single-cycle pulse 34 cycles after start, and busy is high for exactly 33 cycles.
- Signed −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
- 5 / 0 (either mode) → quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, with done 2 cycles after start. A following 9 / 3 → quotient=3, remainder=0, div_by_zero=0.
- 0x80000000 / 0xFFFFFFFF:
  - signed → quotient=0x80000000, remainder=0
  - unsigned → quotient=0, remainder=0x80000000
- Robustness sequence:
  - Assert start again at iteration 5 with different operands → ignored; the original result is returned.
  - Change the dividend after acceptance → no effect on the result.
  - Start in the done cycle → accepted; its done follows 34 cycles later.
- Pulse clear at iteration 10 of 1000 / 10 → busy=0 and all outputs 0 at once, with no done. A new 1000 / 10 then completes with quotient=100, remainder=0.
